// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a PC-indexed table of 2-bit saturating counters
// predicts in IF. Each prediction travels through IF/ID and ID/EX, and the
// counter is trained when the branch resolves in EX.
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] IF_pc,
    input  logic              IF_is_branch,
    input  logic [ADDR_W-1:0] IF_target,
    input  logic              stall,
    input  logic              flush,
    input  logic              EX_resolve,
    input  logic              EX_taken,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    output logic              EX_feedback_valid,
    output logic              EX_prediction_incorrect
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          cnt [ENTRIES];
    logic [IDX_BITS-1:0] idx;
    logic [ADDR_W-1:0]   pc_plus4;

    logic                if_id_valid;
    logic                if_id_pred;
    logic [IDX_BITS-1:0] if_id_idx;
    logic                id_ex_valid;
    logic                id_ex_pred;
    logic [IDX_BITS-1:0] id_ex_idx;

    // IF-stage prediction and EX-stage feedback; table read has no bypass
    always_comb begin
        idx                     = IF_pc[IDX_BITS+1:2];
        pc_plus4                = IF_pc + ADDR_W'(4);
        pred_taken              = IF_is_branch & cnt[idx][1];
        pred_next_pc            = pred_taken ? IF_target : pc_plus4;
        EX_feedback_valid       = EX_resolve & id_ex_valid & ~stall;
        EX_prediction_incorrect = EX_feedback_valid & (EX_taken != id_ex_pred);
    end

    // Carry each prediction alongside its instruction; stall overrides flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pred  <= 1'b0;
            if_id_idx   <= '0;
            id_ex_valid <= 1'b0;
            id_ex_pred  <= 1'b0;
            id_ex_idx   <= '0;
        end else if (!stall) begin
            if (flush) begin
                if_id_valid <= 1'b0;
                id_ex_valid <= 1'b0;
            end else begin
                if_id_valid <= IF_is_branch;
                if_id_pred  <= pred_taken;
                if_id_idx   <= idx;
                id_ex_valid <= if_id_valid;
                id_ex_pred  <= if_id_pred;
                id_ex_idx   <= if_id_idx;
            end
        end
    end

    // Train the resolved branch's counter, saturating at both ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt[i] <= 2'b01;
            end
        end else if (EX_feedback_valid) begin
            if (EX_taken) begin
                if (cnt[id_ex_idx] != 2'b11) begin
                    cnt[id_ex_idx] <= cnt[id_ex_idx] + 2'd1;
                end
            end else begin
                if (cnt[id_ex_idx] != 2'b00) begin
                    cnt[id_ex_idx] <= cnt[id_ex_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_pc;
    logic        IF_is_branch;
    logic [31:0] IF_target;
    logic        stall;
    logic        flush;
    logic        EX_resolve;
    logic        EX_taken;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        EX_feedback_valid;
    logic        EX_prediction_incorrect;

    int n_checks;
    int n_pass;

    branch_predictor #(.IDX_BITS(4), .ADDR_W(32)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .IF_pc                   (IF_pc),
        .IF_is_branch            (IF_is_branch),
        .IF_target               (IF_target),
        .stall                   (stall),
        .flush                   (flush),
        .EX_resolve              (EX_resolve),
        .EX_taken                (EX_taken),
        .pred_taken              (pred_taken),
        .pred_next_pc            (pred_next_pc),
        .EX_feedback_valid       (EX_feedback_valid),
        .EX_prediction_incorrect (EX_prediction_incorrect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one branch in IF, let it travel two stages, then resolve it in EX
    task automatic run_branch(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic taken, input logic exp_pred, input logic exp_inc);
        IF_pc = pc; IF_target = tgt; IF_is_branch = 1'b1;
        #1;
        check({tag, " pred"}, 32'(pred_taken), 32'(exp_pred));
        check({tag, " npc"}, pred_next_pc, exp_pred ? tgt : pc + 32'd4);
        cycle();
        IF_is_branch = 1'b0; IF_pc = 32'h1000;
        cycle();
        EX_resolve = 1'b1; EX_taken = taken;
        #1;
        check({tag, " fbv"}, 32'(EX_feedback_valid), 32'd1);
        check({tag, " inc"}, 32'(EX_prediction_incorrect), 32'(exp_inc));
        cycle();
        EX_resolve = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; IF_pc = 32'h40; IF_is_branch = 1'b1; IF_target = 32'h100;
        stall = 1'b0; flush = 1'b0; EX_resolve = 1'b0; EX_taken = 1'b0;
        cycle(); cycle();
        check("rst pred", 32'(pred_taken), 32'd0);
        check("rst npc", pred_next_pc, 32'h44);
        check("rst fbv", 32'(EX_feedback_valid), 32'd0);
        check("rst inc", 32'(EX_prediction_incorrect), 32'd0);
        rst_n = 1'b1;
        IF_is_branch = 1'b0;
        cycle();

        // Train idx 0 up to saturation, then down to saturation
        run_branch("t1", 32'h40, 32'h100, 1'b1, 1'b0, 1'b1);
        check("t1 cnt0", 32'(dut.cnt[0]), 32'd2);
        run_branch("t2", 32'h40, 32'h100, 1'b1, 1'b1, 1'b0);
        run_branch("t3", 32'h40, 32'h100, 1'b1, 1'b1, 1'b0);
        check("sat hi", 32'(dut.cnt[0]), 32'd3);
        run_branch("n1", 32'h40, 32'h100, 1'b0, 1'b1, 1'b1);
        run_branch("n2", 32'h40, 32'h100, 1'b0, 1'b1, 1'b1);
        run_branch("n3", 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);
        run_branch("n4", 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);
        check("sat lo", 32'(dut.cnt[0]), 32'd0);

        // Aliasing: 0x04 and 0x44 share idx 1
        run_branch("al04", 32'h04, 32'h200, 1'b1, 1'b0, 1'b1);
        run_branch("al44", 32'h44, 32'h300, 1'b0, 1'b1, 1'b1);

        // Stall holds EX and suppresses feedback
        IF_pc = 32'h40; IF_is_branch = 1'b1; IF_target = 32'h100;
        #1; check("st pred", 32'(pred_taken), 32'd0);
        cycle();
        IF_is_branch = 1'b0;
        cycle();
        stall = 1'b1; EX_resolve = 1'b1; EX_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; check("st fbv", 32'(EX_feedback_valid), 32'd0);
            cycle();
        end
        check("st cnt", 32'(dut.cnt[0]), 32'd0);
        stall = 1'b0;
        #1;
        check("st rel fbv", 32'(EX_feedback_valid), 32'd1);
        check("st rel inc", 32'(EX_prediction_incorrect), 32'd1);
        cycle();
        check("st one pulse", 32'(EX_feedback_valid), 32'd0);
        check("st cnt2", 32'(dut.cnt[0]), 32'd1);
        EX_resolve = 1'b0;

        // Flush squashes an in-flight prediction
        IF_pc = 32'h40; IF_is_branch = 1'b1;
        cycle();
        IF_is_branch = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0; EX_resolve = 1'b1; EX_taken = 1'b1;
        #1; check("fl fbv", 32'(EX_feedback_valid), 32'd0);
        cycle();
        check("fl cnt", 32'(dut.cnt[0]), 32'd1);
        EX_resolve = 1'b0;

        // Same-index read/write: IF sees the pre-update value
        IF_pc = 32'h08; IF_target = 32'h400; IF_is_branch = 1'b1;
        #1; check("rw pred0", 32'(pred_taken), 32'd0);
        cycle();
        IF_is_branch = 1'b0;
        cycle();
        IF_is_branch = 1'b1; EX_resolve = 1'b1; EX_taken = 1'b1;
        #1;
        check("rw fbv", 32'(EX_feedback_valid), 32'd1);
        check("rw old", 32'(pred_taken), 32'd0);
        cycle();
        EX_resolve = 1'b0;
        #1;
        check("rw new", 32'(pred_taken), 32'd1);
        check("rw npc", pred_next_pc, 32'h400);
        cycle();
        cycle();

        // Asynchronous reset mid-stream with a valid entry in EX
        EX_resolve = 1'b1; EX_taken = 1'b1;
        #1; check("mr pre fbv", 32'(EX_feedback_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr fbv", 32'(EX_feedback_valid), 32'd0);
        check("mr pred", 32'(pred_taken), 32'd0);
        check("mr npc", pred_next_pc, 32'h0C);
        check("mr cnt2", 32'(dut.cnt[2]), 32'd1);
        EX_resolve = 1'b0;
        cycle();
        rst_n = 1'b1;

        // PC+4 wraps
        IF_pc = 32'hFFFF_FFFC; IF_is_branch = 1'b0;
        #1; check("wrap npc", pred_next_pc, 32'h0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch predictor with a table of 2-bit saturating counters, indexed by PC.
- Gives a taken/not-taken prediction in IF for pre-decoded branches.
- Carries each prediction down the IF/ID and ID/EX stages alongside the instruction.
- At EX it compares the prediction with the resolved outcome, trains the counter, and drives the feedback pair consumed by the prediction performance counter block.

Parameters:
- IDX_BITS, 4, log2 of counter-table entries (default gives 16 entries).
- ADDR_W, 32, PC width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- IF_pc  input  ADDR_W  PC of the instruction currently in IF
- IF_is_branch  input  1  pre-decode: IF instruction is a conditional branch
- IF_target  input  ADDR_W  pre-decoded branch target of the IF instruction
- stall  input  1  pipeline stall; freezes all tracking state
- flush  input  1  squash the IF/ID and ID/EX entries (asserted on redirect)
- EX_resolve  input  1  a conditional branch is in EX and its outcome is valid
- EX_taken  input  1  resolved direction of the EX branch
- pred_taken  output  1  IF prediction
- pred_next_pc  output  ADDR_W  next fetch PC chosen by the predictor
- EX_feedback_valid  output  1  a prediction is being resolved this cycle
- EX_prediction_incorrect  output  1  the resolved prediction was wrong

Behaviour:
- Reset is asynchronous and active-low, on rst_n.
  - Every table counter resets to 2'b01 (weakly not-taken).
  - All tracking registers reset to 0.
  - Reset values: pred_taken=0, pred_next_pc=IF_pc+4, EX_feedback_valid=0, EX_prediction_incorrect=0.
- Index is IF_pc[IDX_BITS+1:2]; PC bits [1:0] are ignored.
- Prediction path (combinational, same cycle):
  - pred_taken = IF_is_branch & cnt[idx][1].
  - pred_next_pc = pred_taken ? IF_target : IF_pc+4.
  - The +4 add wraps modulo 2^ADDR_W.
- Tracking registers: IF_ID {valid, pred, idx} and ID_EX {valid, pred, idx}.
  - When stall=0 and flush=0: IF_ID <= {IF_is_branch, pred_taken, idx}; ID_EX <= IF_ID.
  - When stall=1: both stages hold, regardless of flush.
  - When flush=1 and stall=0: IF_ID.valid <= 0 and ID_EX.valid <= 0. The pred/idx fields are don't-care.
- Feedback (combinational from registered state plus EX inputs):
  - EX_feedback_valid = EX_resolve & ID_EX.valid & ~stall.
  - EX_prediction_incorrect = EX_feedback_valid & (EX_taken != ID_EX.pred).
  - An EX_resolve with ID_EX.valid=0 produces no feedback and no training.
- Training happens at the posedge of a cycle with EX_feedback_valid=1, on cnt[ID_EX.idx]:
  - EX_taken=1: increment, saturating at 2'b11.
  - EX_taken=0: decrement, saturating at 2'b00.
  - Only one counter changes per cycle.
- Same-index read and write in one cycle: the IF read returns the pre-update value. There is no bypass; the new value is visible from the next cycle.
- Aliasing: PCs sharing the same index bits share one counter. This is intended.
- Flush in the same cycle as feedback: training uses the current ID_EX contents, then ID_EX is cleared.
- Reset mid-operation: the table and all tracking state clear immediately. In-flight predictions are dropped with no feedback.
- Latency: a prediction made in IF at cycle t reaches EX at t+2 when no stalls occur. Each stall cycle adds one.

Test Plan:
- Reset, then branch at PC 0x40 (idx 0) with IF_target 0x100 -> pred_taken=0, pred_next_pc=0x44. Two cycles later EX_resolve=1, EX_taken=1 -> EX_feedback_valid=1, EX_prediction_incorrect=1, cnt[0]=2'b10.
- Repeat the same branch at PC 0x40, taken -> second pass pred_taken=1, pred_next_pc=0x100, incorrect=0. Third taken pass saturates cnt[0] at 2'b11. Then four not-taken resolutions -> counter reaches 2'b00 and stays there; predictions flip to not-taken after the second one.
- Branches at PC 0x04 and 0x44 (both idx 1) -> both use one shared counter; training via 0x04 changes the prediction for 0x44.
- Predict at PC 0x40, assert stall for 3 cycles while EX_resolve=1 -> feedback stays 0 and the counter is unchanged. Deassert stall -> exactly one feedback pulse.
- Branch in IF/ID, flush=1 -> one cycle later ID_EX.valid=0; the following EX_resolve=1 gives feedback_valid=0 and no training.
- EX training idx 2 while IF reads PC 0x08 (idx 2) in the same cycle -> IF sees the old counter value; the next-cycle read sees the updated value. Assert rst_n=0 mid-stream -> all outputs and counters return to their reset values immediately.
